// File: rtl/param_scan_fifo.sv
// Parametrised synchronous FIFO with occupancy count, programmable almost flags,
// sticky overflow/underflow, and a full-storage scan chain selected by TM.
module param_scan_fifo #(
    parameter int WIDTH    = 9,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     TM,
    input  logic                     SI,
    output logic                     SO
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int MW = DEPTH * WIDTH;
    localparam int CL = MW + WIDTH;

    // Storage is one flat vector so that entry i, bit b sits at chain position i*WIDTH+b.
    logic [MW-1:0]  mem_flat;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CL:0]    chain_shift;
    logic           push_ok;
    logic           pop_ok;

    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(AF_LEVEL));
    assign almost_empty = (count <= CW'(AE_LEVEL));

    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop);

    // Chain shifted by one: SI enters at bit 0, the top bit falls out as SO.
    assign chain_shift = {dout, mem_flat, SI};
    assign SO          = chain_shift[CL];

    // Memory has no reset value; it simply holds while reset is asserted.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            dout      <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (TM) begin
            mem_flat <= chain_shift[MW-1:0];
            dout     <= chain_shift[CL-1:MW];
        end else begin
            if (push_ok) begin
                mem_flat[wr_ptr*WIDTH +: WIDTH] <= din;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                dout   <= mem_flat[rd_ptr*WIDTH +: WIDTH];
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end
            if (pop && !pop_ok) begin
                underflow <= 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_param_scan_fifo.sv
// Randomised self-checking bench for param_scan_fifo against a queue-based FIFO model.
module tb_param_scan_fifo;

    localparam int W = 9;
    localparam int D = 8;
    localparam int L = (D + 1) * W;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         push  = 1'b0;
    logic         pop   = 1'b0;
    logic [W-1:0] din   = '0;
    logic         TM    = 1'b0;
    logic         SI    = 1'b0;
    logic [W-1:0] dout;
    logic         full, empty, almost_full, almost_empty;
    logic [3:0]   count;
    logic         overflow, underflow, SO;

    param_scan_fifo #(.WIDTH(W), .DEPTH(D)) dut (
        .clock(clock), .reset(reset), .push(push), .pop(pop), .din(din),
        .dout(dout), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count), .overflow(overflow),
        .underflow(underflow), .TM(TM), .SI(SI), .SO(SO)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Reference model: a word queue plus the spec-level storage image and slot indices.
    logic [W-1:0] q[$];
    logic [W-1:0] mem_m[D];
    int           wr_i, rd_i;
    logic [W-1:0] exp_dout;
    bit           ovf_m, udf_m;

    function automatic logic [18:0] exp_status();
        int c;
        c = q.size();
        return {exp_dout, 4'(c), c == D, c == 0, c >= D - 2, c <= 2, ovf_m, udf_m};
    endfunction

    function automatic logic [18:0] dut_status();
        return {dout, count, full, empty, almost_full, almost_empty, overflow, underflow};
    endfunction

    task automatic model_reset();
        q.delete();
        wr_i = 0;
        rd_i = 0;
        exp_dout = '0;
        ovf_m = 1'b0;
        udf_m = 1'b0;
    endtask

    // Drives one functional cycle (called at 1 ns after a rising edge) and advances the model.
    task automatic do_cycle(input logic p, input logic po, input logic [W-1:0] d);
        bit was_full, was_empty, pa, wa;
        push = p;
        pop  = po;
        din  = d;
        was_full  = (q.size() == D);
        was_empty = (q.size() == 0);
        pa = po && !was_empty;
        wa = p && (!was_full || po);
        @(posedge clock);
        #1;
        if (p && !wa) ovf_m = 1'b1;
        if (po && !pa) udf_m = 1'b1;
        if (pa) begin
            exp_dout = q.pop_front();
            rd_i = (rd_i + 1) % D;
        end
        if (wa) begin
            q.push_back(d);
            mem_m[wr_i] = d;
            wr_i = (wr_i + 1) % D;
        end
        $display("t=%0t push=%0b pop=%0b din=%h -> dout=%h count=%0d", $time, p, po, d, dout, count);
        push = 1'b0;
        pop  = 1'b0;
    endtask

    task automatic reset_dut();
        push = 1'b0;
        pop  = 1'b0;
        TM   = 1'b0;
        reset = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if ({dut_status(), SO} !== {exp_status(), 1'b0}) begin
            failures++;
            $display("FAIL reset_hold: got %h want %h", {dut_status(), SO}, {exp_status(), 1'b0});
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if ({dut_status(), SO} !== {exp_status(), 1'b0}) begin
            failures++;
            $display("FAIL reset_release: got %h want %h", {dut_status(), SO}, {exp_status(), 1'b0});
        end
    endtask

    task automatic test_fill_drain();
        reset_dut();
        for (int i = 1; i <= 9; i++) begin
            do_cycle(1'b1, 1'b0, (i == 9) ? 9'h1FF : 9'(i));
            checks++;
            if (dut_status() !== exp_status()) begin
                failures++;
                $display("FAIL fill_%0d: got %h want %h", i, dut_status(), exp_status());
            end
        end
        for (int i = 1; i <= 9; i++) begin
            do_cycle(1'b0, 1'b1, '0);
            checks++;
            if (dut_status() !== exp_status()) begin
                failures++;
                $display("FAIL drain_%0d: got %h want %h", i, dut_status(), exp_status());
            end
        end
    endtask

    task automatic test_simultaneous();
        reset_dut();
        for (int i = 0; i < D; i++) do_cycle(1'b1, 1'b0, 9'($urandom_range(0, 511)));
        do_cycle(1'b1, 1'b1, 9'h0AA);
        checks++;
        if (dut_status() !== exp_status()) begin
            failures++;
            $display("FAIL full_push_pop: got %h want %h", dut_status(), exp_status());
        end
        for (int i = 0; i < D; i++) begin
            do_cycle(1'b0, 1'b1, '0);
            checks++;
            if (dut_status() !== exp_status()) begin
                failures++;
                $display("FAIL full_drain_%0d: got %h want %h", i, dut_status(), exp_status());
            end
        end
        do_cycle(1'b1, 1'b1, 9'($urandom_range(0, 511)));
        checks++;
        if (dut_status() !== exp_status()) begin
            failures++;
            $display("FAIL empty_push_pop: got %h want %h", dut_status(), exp_status());
        end
    endtask

    task automatic test_wrap();
        int op;
        reset_dut();
        do_cycle(1'b1, 1'b0, 9'($urandom_range(0, 511)));
        do_cycle(1'b1, 1'b0, 9'($urandom_range(0, 511)));
        for (int i = 0; i < 20; i++) begin
            op = $urandom_range(0, 2);
            if (q.size() == 1 && op == 1) op = 0;
            if (q.size() == 3 && op == 0) op = 1;
            do_cycle(op != 1, op != 0, 9'($urandom_range(0, 511)));
            checks++;
            if (dut_status() !== exp_status()) begin
                failures++;
                $display("FAIL wrap_%0d: got %h want %h", i, dut_status(), exp_status());
            end
        end
    endtask

    task automatic test_random();
        reset_dut();
        for (int i = 0; i < 150; i++) begin
            do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)));
            checks++;
            if (dut_status() !== exp_status()) begin
                failures++;
                $display("FAIL random_%0d: got %h want %h", i, dut_status(), exp_status());
            end
        end
    endtask

    task automatic test_scan();
        bit pat_a[L];
        bit pat_b[L];
        logic [W-1:0] w;
        int held;
        reset_dut();
        for (int i = 0; i < 5; i++) do_cycle(1'b1, 1'b0, 9'($urandom_range(0, 511)));
        do_cycle(1'b0, 1'b1, '0);
        do_cycle(1'b0, 1'b1, '0);
        held = q.size();
        for (int k = 0; k < L; k++) begin
            pat_a[k] = 1'($urandom_range(0, 1));
            pat_b[k] = 1'($urandom_range(0, 1));
        end
        TM = 1'b1;
        for (int k = 0; k < 2 * L; k++) begin
            SI   = (k < L) ? pat_a[k] : pat_b[k - L];
            push = 1'($urandom_range(0, 1));
            pop  = 1'($urandom_range(0, 1));
            din  = 9'($urandom_range(0, 511));
            if (k >= L) begin
                checks++;
                if (SO !== pat_a[k - L]) begin
                    failures++;
                    $display("FAIL scan_out_%0d: got %b want %b", k - L, SO, pat_a[k - L]);
                end
            end
            @(posedge clock);
            #1;
            checks++;
            if ({count, overflow, underflow} !== {4'(held), 2'b00}) begin
                failures++;
                $display("FAIL scan_hold_%0d: got %h want %h", k, {count, overflow, underflow}, {4'(held), 2'b00});
            end
        end
        TM = 1'b0;
        push = 1'b0;
        pop  = 1'b0;
        // After the second pattern, chain position p holds pat_b[L-1-p].
        for (int i = 0; i < D; i++) begin
            for (int b = 0; b < W; b++) w[b] = pat_b[L - 1 - (i * W + b)];
            mem_m[i] = w;
        end
        for (int b = 0; b < W; b++) w[b] = pat_b[L - 1 - (D * W + b)];
        exp_dout = w;
        q.delete();
        for (int j = 0; j < held; j++) q.push_back(mem_m[(rd_i + j) % D]);
        checks++;
        if (dout !== exp_dout) begin
            failures++;
            $display("FAIL scan_dout: got %h want %h", dout, exp_dout);
        end
        for (int j = 0; j < held; j++) begin
            do_cycle(1'b0, 1'b1, '0);
            checks++;
            if (dut_status() !== exp_status()) begin
                failures++;
                $display("FAIL scan_pop_%0d: got %h want %h", j, dut_status(), exp_status());
            end
        end
        do_cycle(1'b1, 1'b0, 9'h155);
        do_cycle(1'b0, 1'b1, '0);
        checks++;
        if (dut_status() !== exp_status()) begin
            failures++;
            $display("FAIL scan_resume: got %h want %h", dut_status(), exp_status());
        end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        for (int i = 0; i < 5; i++) do_cycle(1'b1, 1'b0, 9'($urandom_range(0, 511)));
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({dut_status(), SO} !== {exp_status(), 1'b0}) begin
            failures++;
            $display("FAIL reset_mid_op: got %h want %h", {dut_status(), SO}, {exp_status(), 1'b0});
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        TM = 1'b1;
        SI = 1'b1;
        repeat (L) @(posedge clock);
        #1;
        checks++;
        if ({SO, dout} !== {1'b1, 9'h1FF}) begin
            failures++;
            $display("FAIL scan_ones: got %h want %h", {SO, dout}, {1'b1, 9'h1FF});
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({dut_status(), SO} !== {exp_status(), 1'b0}) begin
            failures++;
            $display("FAIL reset_mid_scan: got %h want %h", {dut_status(), SO}, {exp_status(), 1'b0});
        end
        TM = 1'b0;
        SI = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_simultaneous();
        test_wrap();
        test_random();
        test_scan();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/param_scan_fifo.md
# param_scan_fifo

Parametrised synchronous FIFO with a built-in scan chain. It is the successor to the fixed 9-bit scan FIFO and adds configurable width and depth, an occupancy count, programmable almost-full and almost-empty flags, and sticky overflow and underflow error flags. It sits between producer and consumer datapaths on a single clock domain. `TM` turns the storage and output register into one serial shift chain for test.

## Interface
- `WIDTH`, 9, data word width in bits (≥1).
- `DEPTH`, 8, number of entries; power of two, ≥2.
- `AF_LEVEL`, DEPTH-2, `almost_full` asserts when count ≥ AF_LEVEL.
- `AE_LEVEL`, 2, `almost_empty` asserts when count ≤ AE_LEVEL.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `push`  in  1  write request.
- `pop`  in  1  read request.
- `din`  in  WIDTH  write data.
- `dout`  out  WIDTH  registered read data.
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `almost_full`  out  1  see AF_LEVEL.
- `almost_empty`  out  1  see AE_LEVEL.
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky: a push was rejected.
- `underflow`  out  1  sticky: a pop was rejected.
- `TM`  in  1  test mode: enables scan shift.
- `SI`  in  1  scan input.
- `SO`  out  1  scan output.

## Operation
- Reset (`reset`=0, asynchronous): write pointer, read pointer, count, `dout`, `overflow` and `underflow` all go to 0. As a result `empty`=1, `almost_empty`=1, `full`=0 and `almost_full`=0. Memory contents are not reset.
- Functional mode (`TM`=0):
  - Accepted push: `din` is written to mem[wr_ptr], and wr_ptr increments modulo DEPTH.
  - Accepted pop: `dout` is loaded with mem[rd_ptr], and rd_ptr increments modulo DEPTH.
  - Without an accepted pop, `dout` holds its value.
  - A push is accepted if `full`=0, or if `full`=1 and `pop`=1 in the same cycle. In that case both the push and the pop proceed and count is unchanged.
  - A pop is accepted only if `empty`=0. When `empty`=1 and push and pop arrive together, the push is accepted, the pop is rejected and count becomes 1.
  - A rejected push sets `overflow`. A rejected pop sets `underflow`. Both flags stay set until reset.
  - count changes by +1 (push only), −1 (pop only) or 0 (both or neither).
- Flags are combinational decodes of the registered count. There are no other registered flag states.
- Pointers wrap from DEPTH-1 to 0 with no gap.
- Scan mode (`TM`=1):
  - Every rising edge shifts the chain by one bit.
  - Chain order: `SI` → mem[0][0] … mem[0][WIDTH-1] → mem[1][0] … mem[DEPTH-1][WIDTH-1] → dout[0] … dout[WIDTH-1] → `SO`.
  - `SO` = dout[WIDTH-1]. Chain length is (DEPTH+1)·WIDTH.
  - push and pop are ignored. Pointers, count, `overflow` and `underflow` hold, and no error flag is set.
- When `TM` returns to 0, FIFO operation resumes with the shifted-in memory contents and the held pointers.
- Reset takes priority over everything, including an in-progress scan shift.

## Timing
- Write-to-read latency: a word pushed at edge N can be popped at edge N+1. Its data is on `dout` after edge N+1.
- Pop-to-data latency: 1 cycle (`dout` is valid after the edge that accepts the pop).
- count and all flags update on the same edge as the push or pop that changes them.
- Scan shift: 1 bit per cycle. A bit entering at `SI` appears at `SO` after (DEPTH+1)·WIDTH edges.
- Asynchronous reset takes effect immediately on assertion. Release is sampled at the next rising edge.

## Test plan
- Reset with defaults: hold `reset`=0, then release. Required: count=0, `empty`=1, `almost_empty`=1, `dout`=0, `SO`=0.
- Fill then drain: push 0x001..0x008, then push 0x1FF.
  - After 8 pushes: `full`=1. `almost_full` first asserts after the 6th push.
  - The 9th push is rejected and sets `overflow`=1.
  - Popping 8 returns 0x001..0x008 in order with 1-cycle latency. A 9th pop sets `underflow`=1 and `dout` stays 0x008.
- Simultaneous ops:
  - On a full FIFO, push 0x0AA with a pop: count stays 8, `overflow` stays 0, and 0x0AA comes out last.
  - On an empty FIFO, push with a pop: count=1 and `underflow`=1.
- Wrap-around: 20 interleaved push/pop cycles keeping count between 1 and 3. Data order is preserved across pointer wrap, and `almost_empty` tracks count ≤2.
- Scan: with `TM`=1, shift 81 bits of a known pattern into `SI`, then shift 81 more. The first pattern emerges on `SO` unchanged. count and the pointers are unchanged throughout. After `TM`=0, popping returns the scanned-in memory word at the held rd_ptr.
- Reset mid-operation: assert `reset` with count=5 and again mid-scan. All outputs return to their reset values immediately, without waiting for a clock edge.
